// File: rtl/cmd_frame_builder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// cmd_frame_builder
//   Builds the 48-bit SD command frame with serially computed CRC7 and hands
//   it to parallel_to_serial through the start_sending/finished handshake.
// Revision: 1.0 - initial release
// ============================================================================
module cmd_frame_builder #(
  parameter int TIMEOUT_CYCLES = 200
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        cmd_req,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_argument,
  input  logic        finished,
  output logic        busy,
  output logic        start_sending,
  output logic [47:0] parallel_in,
  output logic        frame_done,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_SEND = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [7:0] C_TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [5:0] C_LAST_BIT = 6'd39;

  // Reset asserts asynchronously but is released on a clock edge.
  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) r_rst_sync <= 2'b00;
    else          r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign w_rst_n = r_rst_sync[1];

  state_t      r_state, w_state_nxt;
  logic [5:0]  r_index, w_index_nxt;
  logic [31:0] r_arg, w_arg_nxt;
  logic [5:0]  r_bit_cnt, w_bit_cnt_nxt;
  logic [6:0]  r_crc, w_crc_nxt;
  logic [7:0]  r_tmo_cnt, w_tmo_cnt_nxt;
  logic        w_busy_nxt, w_start_nxt, w_done_nxt, w_tmo_err_nxt;
  logic [47:0] w_pin_nxt;

  logic [39:0] w_hdr;
  logic        w_bit, w_fb;
  logic [6:0]  w_crc_step;

  assign w_hdr      = {2'b01, r_index, r_arg};
  assign w_bit      = w_hdr[C_LAST_BIT - r_bit_cnt];
  assign w_fb       = w_bit ^ r_crc[6];
  assign w_crc_step = {r_crc[5:3], r_crc[2] ^ w_fb, r_crc[1:0], w_fb};

  always_ff @(posedge CLK or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state       <= S_IDLE;
      r_index       <= 6'd0;
      r_arg         <= 32'd0;
      r_bit_cnt     <= 6'd0;
      r_crc         <= 7'd0;
      r_tmo_cnt     <= 8'd0;
      busy          <= 1'b0;
      start_sending <= 1'b0;
      parallel_in   <= 48'h0;
      frame_done    <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_index       <= w_index_nxt;
      r_arg         <= w_arg_nxt;
      r_bit_cnt     <= w_bit_cnt_nxt;
      r_crc         <= w_crc_nxt;
      r_tmo_cnt     <= w_tmo_cnt_nxt;
      busy          <= w_busy_nxt;
      start_sending <= w_start_nxt;
      parallel_in   <= w_pin_nxt;
      frame_done    <= w_done_nxt;
      timeout_err   <= w_tmo_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_index_nxt   = r_index;
    w_arg_nxt     = r_arg;
    w_bit_cnt_nxt = r_bit_cnt;
    w_crc_nxt     = r_crc;
    w_tmo_cnt_nxt = r_tmo_cnt;
    w_busy_nxt    = busy;
    w_start_nxt   = start_sending;
    w_pin_nxt     = parallel_in;
    w_done_nxt    = 1'b0;
    w_tmo_err_nxt = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (cmd_req) begin
          w_index_nxt   = cmd_index;
          w_arg_nxt     = cmd_argument;
          w_busy_nxt    = 1'b1;
          w_bit_cnt_nxt = 6'd0;
          w_crc_nxt     = 7'd0;
          w_state_nxt   = S_CALC;
        end
      end
      S_CALC: begin
        w_crc_nxt     = w_crc_step;
        w_bit_cnt_nxt = r_bit_cnt + 6'd1;
        if (r_bit_cnt == C_LAST_BIT) begin
          // Final CRC comes straight from this cycle's step, not the register.
          w_pin_nxt     = {w_hdr, w_crc_step, 1'b1};
          w_start_nxt   = 1'b1;
          w_tmo_cnt_nxt = 8'd0;
          w_state_nxt   = S_SEND;
        end
      end
      S_SEND: begin
        if (finished) begin
          w_start_nxt = 1'b0;
          w_done_nxt  = 1'b1;
          w_state_nxt = S_DONE;
        end else if (r_tmo_cnt == C_TMO_LAST) begin
          w_start_nxt   = 1'b0;
          w_tmo_err_nxt = 1'b1;
          w_state_nxt   = S_DONE;
        end else begin
          w_tmo_cnt_nxt = r_tmo_cnt + 8'd1;
        end
      end
      S_DONE: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_cmd_frame_builder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_cmd_frame_builder
//   Scoreboarded bench for cmd_frame_builder with a parallel_to_serial model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_cmd_frame_builder;

  localparam int TMO = 200;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cmd_req = 1'b0;
  logic [5:0]  cmd_index = 6'd0;
  logic [31:0] cmd_argument = 32'd0;
  logic        finished = 1'b0;
  logic        busy, start_sending, frame_done, timeout_err;
  logic [47:0] parallel_in;

  always #5 clk = ~clk;

  cmd_frame_builder #(.TIMEOUT_CYCLES(TMO)) dut (
    .CLK          (clk),
    .RESET_N      (rst_n),
    .cmd_req      (cmd_req),
    .cmd_index    (cmd_index),
    .cmd_argument (cmd_argument),
    .finished     (finished),
    .busy         (busy),
    .start_sending(start_sending),
    .parallel_in  (parallel_in),
    .frame_done   (frame_done),
    .timeout_err  (timeout_err)
  );

  int          n_checks = 0;
  int          n_pass = 0;
  logic [47:0] exp_q[$];
  int          frames_seen = 0;
  int          pulses_seen = 0;
  bit          ser_en = 1'b0;
  int          ser_cnt = 0;
  bit          prev_ss = 1'b0;
  logic        fin_sampled = 1'b0;

  function automatic logic [47:0] model_frame(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] h;
    logic [6:0]  c;
    logic        fb;
    h = {2'b01, idx, arg};
    c = 7'd0;
    for (int i = 39; i >= 0; i--) begin
      fb = h[i] ^ c[6];
      c  = {c[5:3], c[2] ^ fb, c[1:0], fb};
    end
    return {h, c, 1'b1};
  endfunction

  always @(posedge clk) fin_sampled <= finished;

  // Serializer model: raise finished for one cycle 48 cycles into a frame.
  always @(negedge clk) begin
    if (!ser_en || !start_sending) begin
      finished = 1'b0;
      ser_cnt  = 0;
    end else if (finished) begin
      finished = 1'b0;
    end else if (ser_cnt >= 48) begin
      finished = 1'b1;
    end else begin
      ser_cnt++;
    end
  end

  always @(negedge clk) begin
    logic [47:0] e;
    if (start_sending && !prev_ss) begin
      frames_seen++;
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL frame_unexpected: parallel_in=%h with no frame expected", parallel_in);
      end else begin
        e = exp_q.pop_front();
        if (parallel_in !== e) $display("FAIL frame_value: parallel_in=%h required %h", parallel_in, e);
        else n_pass++;
      end
    end
    if (frame_done || timeout_err) begin
      pulses_seen++;
      n_checks++;
      if (frame_done && timeout_err) $display("FAIL pulse_exclusive: frame_done=1 timeout_err=1 required not both");
      else n_pass++;
    end
    prev_ss = start_sending;
  end

  task automatic issue(input logic [5:0] idx, input logic [31:0] arg, input logic [47:0] exp);
    @(negedge clk);
    cmd_req      = 1'b1;
    cmd_index    = idx;
    cmd_argument = arg;
    exp_q.push_back(exp);
    @(negedge clk);
    cmd_req = 1'b0;
  endtask

  task automatic finish_frame(input bit exp_timeout, input string name);
    int n = 0;
    while (!(frame_done || timeout_err) && n < 600) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if ({frame_done, timeout_err} !== (exp_timeout ? 2'b01 : 2'b10))
      $display("FAIL %s_pulse: frame_done,timeout_err=%b%b required %b", name,
               frame_done, timeout_err, exp_timeout ? 2'b01 : 2'b10);
    else n_pass++;
    if (!exp_timeout) begin
      n_checks++;
      if (fin_sampled !== 1'b1) $display("FAIL %s_done_after_finished: finished at edge=%b required 1", name, fin_sampled);
      else n_pass++;
    end
    @(negedge clk);
    n_checks++;
    if ({busy, frame_done, timeout_err} !== 3'b000)
      $display("FAIL %s_idle: busy,frame_done,timeout_err=%b required 000", name, {busy, frame_done, timeout_err});
    else n_pass++;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b required 0", busy); else n_pass++;
    n_checks++;
    if (start_sending !== 1'b0) $display("FAIL reset_start: got %b required 0", start_sending); else n_pass++;
    n_checks++;
    if (parallel_in !== 48'h0) $display("FAIL reset_pin: got %h required 0", parallel_in); else n_pass++;
    n_checks++;
    if (frame_done !== 1'b0) $display("FAIL reset_done: got %b required 0", frame_done); else n_pass++;
    n_checks++;
    if (timeout_err !== 1'b0) $display("FAIL reset_tmo: got %b required 0", timeout_err); else n_pass++;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_cmd0();
    int edges;
    ser_en = 1'b1;
    @(negedge clk);
    cmd_req = 1'b1; cmd_index = 6'd0; cmd_argument = 32'd0;
    exp_q.push_back(48'h40_0000_0000_95);
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    cmd_req = 1'b0;
    n_checks++;
    if (busy !== 1'b1) $display("FAIL cmd0_busy: got %b required 1", busy); else n_pass++;
    while (!start_sending && edges < 100) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    n_checks++;
    if (edges != 41) $display("FAIL cmd0_latency: start_sending after %0d edges required 41", edges); else n_pass++;
    finish_frame(1'b0, "cmd0");
  endtask

  task automatic test_known_cmds();
    issue(6'd8, 32'h0000_01AA, 48'h48_0000_01AA_87);
    finish_frame(1'b0, "cmd8");
    issue(6'd17, 32'h0, 48'h51_0000_0000_55);
    finish_frame(1'b0, "cmd17");
  endtask

  task automatic test_random();
    logic [5:0]  idx;
    logic [31:0] arg;
    for (int i = 0; i < 3; i++) begin
      idx = 6'($urandom);
      arg = $urandom;
      issue(idx, arg, model_frame(idx, arg));
      finish_frame(1'b0, "rand");
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    int hi = 0;
    ser_en = 1'b0;
    issue(6'd1, 32'hDEAD_BEEF, model_frame(6'd1, 32'hDEAD_BEEF));
    while (!start_sending && n < 100) begin
      @(negedge clk);
      n++;
    end
    while (start_sending && hi < 1000) begin
      hi++;
      @(negedge clk);
    end
    n_checks++;
    if (hi != TMO) $display("FAIL tmo_len: start_sending high %0d cycles required %0d", hi, TMO); else n_pass++;
    n_checks++;
    if ({timeout_err, frame_done} !== 2'b10)
      $display("FAIL tmo_pulse: timeout_err,frame_done=%b%b required 10", timeout_err, frame_done);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({busy, timeout_err} !== 2'b00) $display("FAIL tmo_idle: busy,timeout_err=%b required 00", {busy, timeout_err});
    else n_pass++;
  endtask

  task automatic test_busy_reject();
    int f0;
    ser_en = 1'b1;
    f0 = frames_seen;
    issue(6'd0, 32'h0, 48'h40_0000_0000_95);
    repeat (10) @(negedge clk);
    cmd_req = 1'b1; cmd_index = 6'd17; cmd_argument = 32'hFFFF_FFFF;
    @(negedge clk);
    cmd_req = 1'b0;
    finish_frame(1'b0, "reject");
    repeat (60) @(negedge clk);
    n_checks++;
    if (frames_seen - f0 != 1) $display("FAIL reject_count: got %0d frames required 1", frames_seen - f0); else n_pass++;
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL reject_queue: %0d frames outstanding required 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int f0;
    int n = 0;
    int gap = 0;
    ser_en = 1'b1;
    f0 = frames_seen;
    @(negedge clk);
    cmd_req = 1'b1; cmd_index = 6'd8; cmd_argument = 32'h0000_01AA;
    exp_q.push_back(48'h48_0000_01AA_87);
    while (!frame_done && n < 300) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (frame_done !== 1'b1) $display("FAIL b2b_first_done: got %b required 1", frame_done); else n_pass++;
    cmd_index = 6'd0; cmd_argument = 32'h0;
    exp_q.push_back(48'h40_0000_0000_95);
    while (!start_sending && gap < 100) begin
      gap++;
      if (gap == 2) begin
        n_checks++;
        if (busy !== 1'b0) $display("FAIL b2b_idle_busy: got %b required 0", busy); else n_pass++;
      end
      if (gap == 3) begin
        n_checks++;
        if (busy !== 1'b1) $display("FAIL b2b_accept_busy: got %b required 1", busy); else n_pass++;
        cmd_req = 1'b0;
      end
      @(negedge clk);
    end
    n_checks++;
    if (gap != 42) $display("FAIL b2b_gap: start_sending low %0d cycles required 42", gap); else n_pass++;
    finish_frame(1'b0, "b2b_second");
    n_checks++;
    if (frames_seen - f0 != 2) $display("FAIL b2b_count: got %0d frames required 2", frames_seen - f0); else n_pass++;
  endtask

  task automatic test_reset_mid_send();
    int n = 0;
    int p0;
    ser_en = 1'b0;
    issue(6'd0, 32'h0, 48'h40_0000_0000_95);
    while (!start_sending && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    p0 = pulses_seen;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, start_sending, frame_done, timeout_err} !== 4'b0000 || parallel_in !== 48'h0)
      $display("FAIL rst_mid_outputs: busy,start,done,tmo=%b pin=%h required 0000 0",
               {busy, start_sending, frame_done, timeout_err}, parallel_in);
    else n_pass++;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (pulses_seen != p0) $display("FAIL rst_mid_pulses: got %0d pulses required 0", pulses_seen - p0); else n_pass++;
    ser_en = 1'b1;
    issue(6'd0, 32'h0, 48'h40_0000_0000_95);
    finish_frame(1'b0, "after_rst");
  endtask

  initial begin
    test_reset();
    test_cmd0();
    test_known_cmds();
    test_random();
    test_timeout();
    test_busy_reject();
    test_back_to_back();
    test_reset_mid_send();
    repeat (2) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL final_queue: %0d frames outstanding required 0", exp_q.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/cmd_frame_builder.md
Name: cmd_frame_builder

Overview:
Command-path stage directly upstream of parallel_to_serial in the CMD block. It accepts a command index and a 32-bit argument from the host controller and computes CRC7 serially. It then assembles the 48-bit SD command frame and drives the start_sending/parallel_in/finished handshake of the serializer. It reports completion, or a timeout if the serializer never signals finished.

Parameters:
TIMEOUT_CYCLES, 200, max cycles start_sending may stay high without finished before abort (must be >= 48; width of internal counter = 8 bits, so value <= 255)

Ports:
CLK  input  1  system clock, all logic on rising edge
RESET_N  input  1  asynchronous, active-low reset
cmd_req  input  1  level; high in IDLE requests a new command
cmd_index  input  6  command index, sampled when cmd_req accepted
cmd_argument  input  32  command argument, sampled when cmd_req accepted
finished  input  1  from parallel_to_serial: frame fully shifted out
busy  output  1  high from acceptance until return to IDLE
start_sending  output  1  to parallel_to_serial: frame valid, begin shifting
parallel_in  output  48  to parallel_to_serial: assembled frame
frame_done  output  1  one-cycle pulse: frame sent successfully
timeout_err  output  1  one-cycle pulse: serializer did not finish in time

Behaviour:
- Reset (async assert, sync-to-CLK release): state IDLE; busy=0, start_sending=0, parallel_in=48'h0, frame_done=0, timeout_err=0, CRC register=0, counters=0.
- Frame format: [47]=0 start, [46]=1 transmission, [45:40]=cmd_index, [39:8]=cmd_argument, [7:1]=CRC7, [0]=1 end.
- CRC7: poly x^7+x^3+1, init 7'h00, over frame bits [47:8] MSB first, one bit per clock. Per bit: fb = bit ^ crc[6]; crc = {crc[5:3], crc[2]^fb, crc[1:0], fb}.
- States:
  - IDLE: if cmd_req=1, latch index/arg, busy<=1, bit counter<=0, CRC<=0, go CALC. Otherwise hold.
  - CALC: process one bit per cycle. After the 40th bit (counter==39), load parallel_in with the complete frame, set start_sending<=1, clear timeout counter, go SEND.
  - SEND: start_sending and parallel_in held stable.
    - If finished=1: start_sending<=0, frame_done<=1 for one cycle, go DONE.
    - Else if timeout counter == TIMEOUT_CYCLES-1: start_sending<=0, timeout_err<=1 for one cycle, go DONE.
    - Else increment the timeout counter.
  - DONE: busy<=0, go IDLE. This guarantees start_sending is low for at least one cycle before any new frame.
- Latency: start_sending rises exactly 41 rising edges after the edge that accepts cmd_req. busy deasserts 2 edges after finished is sampled high.
- parallel_in keeps its last frame value after SEND and changes only at the CALC->SEND transition.
- cmd_req is ignored while busy=1, including CALC, SEND and DONE. cmd_index/cmd_argument changes after acceptance have no effect.
- cmd_req held high continuously: a new command is accepted on the edge after DONE, giving back-to-back frames.
- finished high outside SEND is ignored.
- finished and the timeout expiring in the same cycle: finished wins (frame_done, no timeout_err).
- frame_done and timeout_err are never high together.
- RESET_N low mid-operation: immediate return to reset values. start_sending drops asynchronously. No frame_done/timeout_err pulse is generated.

Test Plan:
- CMD0: index 0, arg 0 -> parallel_in = 48'h40_0000_0000_95 (CRC7=0x4A), start_sending rises 41 edges after cmd_req accepted. Bench model of parallel_to_serial returns finished -> frame_done pulse, busy low 2 edges later.
- CMD8: index 8, arg 32'h0000_01AA -> parallel_in = 48'h48_0000_01AA_87. CMD17: index 17, arg 0 -> 48'h51_0000_0000_55.
- Timeout: finished tied 0 -> start_sending high for exactly TIMEOUT_CYCLES cycles, then a single timeout_err pulse, no frame_done, busy clears.
- Busy rejection: pulse cmd_req with CMD17 during CALC of a CMD0 -> only the CMD0 frame is produced, and index/arg are unchanged after acceptance.
- Back-to-back: cmd_req held high, CMD8 then CMD0 (inputs changed during DONE) -> two correct frames, with start_sending low for >= 1 cycle between them.
- Reset mid-SEND: RESET_N low while start_sending=1 -> all outputs at reset values immediately, no pulses. After release a fresh CMD0 completes normally.
